// File: rtl/ss_read_data.sv
`default_nettype none
// ============================================================================
//  Module      : ss_read_data
//  Description : Burst reader for an external synchronous RAM. Walks the
//                address range [si..ei] (wrapping), paced by an enable, and
//                returns one registered word per issued address two clocks
//                after issue, flagging the final word with a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module ss_read_data #(
    parameter int SIZE_ADDR = 6,
    parameter int SIZE_DATA = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start_read_data,
    input  logic                 i_en_read_data,
    input  logic [SIZE_ADDR-1:0] i_si_ram,
    input  logic [SIZE_ADDR-1:0] i_ei_ram,
    input  logic [SIZE_DATA-1:0] i_data_ram,
    output logic [SIZE_ADDR-1:0] o_addr_ram,
    output logic [SIZE_DATA-1:0] o_data_ram,
    output logic                 o_data_valid,
    output logic                 o_done_read_data
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SIZE_ADDR-1:0] addr_q,  addr_d;
    logic [SIZE_ADDR-1:0] end_q,   end_d;
    // issue_q marks that the address presented last cycle was issued; the RAM
    // output is therefore valid now. last_q tags that issue as the final one.
    logic                 issue_q, issue_d;
    logic                 last_q,  last_d;
    logic [SIZE_DATA-1:0] data_q,  data_d;
    logic                 valid_q, valid_d;
    logic                 done_q,  done_d;

    // State, address and pipeline registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            issue_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            issue_q <= issue_d;
            last_q  <= last_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next-state: start reloads the range and flushes the pipeline; otherwise
    // an enabled READ cycle issues the current address and advances.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        end_d   = end_q;
        issue_d = 1'b0;
        last_d  = 1'b0;
        data_d  = issue_q ? i_data_ram : data_q;
        valid_d = issue_q;
        done_d  = issue_q & last_q;

        if (i_start_read_data) begin
            state_d = S_READ;
            addr_d  = i_si_ram;
            end_d   = i_ei_ram;
            // Words from an abandoned burst must not leak into the new one.
            data_d  = data_q;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else if (state_q == S_READ && i_en_read_data) begin
            issue_d = 1'b1;
            if (addr_q == end_q) begin
                last_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                // Natural width overflow gives the modulo-2^SIZE_ADDR wrap.
                addr_d = addr_q + SIZE_ADDR'(1);
            end
        end
    end

    assign o_addr_ram       = addr_q;
    assign o_data_ram       = data_q;
    assign o_data_valid     = valid_q;
    assign o_done_read_data = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ss_read_data.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ss_read_data
//  Description : Self-checking bench for ss_read_data: queue-based reference
//                model compared every cycle, directed bursts pinned against
//                literal word lists, then randomized bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ss_read_data;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic [5:0] si = '0;
    logic [5:0] ei = '0;
    logic [7:0] ram_q;
    logic [5:0] addr;
    logic [7:0] data;
    logic       valid;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;
    int s_edge  = 0;

    ss_read_data #(.SIZE_ADDR(6), .SIZE_DATA(8)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start_read_data(start),
        .i_en_read_data   (en),
        .i_si_ram         (si),
        .i_ei_ram         (ei),
        .i_data_ram       (ram_q),
        .o_addr_ram       (addr),
        .o_data_ram       (data),
        .o_data_valid     (valid),
        .o_done_read_data (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_f(input int a);
        return 8'((a + 16) & 255);
    endfunction

    // External synchronous RAM, preloaded mem[a] = a + 0x10.
    always @(posedge clk) ram_q <= mem_f(int'(addr));

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        logic [7:0] word;
        bit         last;
    } exp_t;

    exp_t       pend[$];
    bit         m_active = 1'b0;
    logic [5:0] m_addr = '0;
    logic [5:0] m_end = '0;
    logic       e_valid = 1'b0;
    logic       e_done = 1'b0;
    logic [7:0] e_data = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            m_active = 1'b0;
            m_addr   = '0;
            m_end    = '0;
            e_valid  = 1'b0;
            e_done   = 1'b0;
            e_data   = '0;
        end else begin
            cyc     = cyc + 1;
            e_valid = 1'b0;
            e_done  = 1'b0;
            if (start) begin
                pend.delete();
                m_active = 1'b1;
                m_addr   = si;
                m_end    = ei;
            end else begin
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    e_valid = 1'b1;
                    e_data  = pend[0].word;
                    e_done  = pend[0].last;
                    void'(pend.pop_front());
                end
                if (m_active && en) begin
                    pend.push_back('{cyc + 1, mem_f(int'(m_addr)), m_addr == m_end});
                    if (m_addr == m_end) m_active = 1'b0;
                    else m_addr = m_addr + 6'd1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model: {valid, done, data, addr}.
    always @(negedge clk) begin
        if (chk_en)
            check("cycle", {46'd0, valid, done, data, addr},
                  {46'd0, e_valid, e_done, e_data, m_addr});
    end

    // ---------------- collector for directed literal checks ----------------
    logic [7:0] words[$];
    int         wcyc[$];
    int         dcyc[$];

    always @(negedge clk) begin
        if (rst_n && valid) begin
            words.push_back(data);
            wcyc.push_back(cyc);
        end
        if (rst_n && done) dcyc.push_back(cyc);
    end

    task automatic clear_log();
        words.delete();
        wcyc.delete();
        dcyc.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int s, input int e);
        si    = 6'(s);
        ei    = 6'(e);
        start = 1'b1;
        tick(1);
        s_edge = cyc;
        start  = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!m_active && pend.size() == 0) break;
            tick(1);
        end
        check({nm, "_timeout"}, 64'(i >= budget), 64'd0);
        tick(2);
    endtask

    task automatic check_words(input string nm, input logic [7:0] ex[$]);
        check({nm, "_count"}, 64'(words.size()), 64'(ex.size()));
        for (int i = 0; i < ex.size() && i < words.size(); i++)
            check({nm, "_word"}, 64'(words[i]), 64'(ex[i]));
        check({nm, "_done_count"}, 64'(dcyc.size()), 64'd1);
        if (dcyc.size() > 0 && wcyc.size() > 0)
            check({nm, "_done_with_last"}, 64'(dcyc[0]), 64'(wcyc[wcyc.size()-1]));
    endtask

    logic [7:0] ex[$];

    initial begin
        // Reset state
        tick(2);
        check("reset_outputs", {40'd0, valid, done, data, addr}, 64'd0);
        rst_n = 1'b1;
        tick(1);
        chk_en = 1'b1;
        tick(2);

        // Burst 5..10 with enable held high
        clear_log();
        en = 1'b1;
        do_start(5, 10);
        wait_idle("b5_10", 40);
        ex = '{8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A};
        check_words("b5_10", ex);
        if (wcyc.size() == 6) begin
            check("b5_10_first_latency", 64'(wcyc[0]), 64'(s_edge + 2));
            check("b5_10_contiguous", 64'(wcyc[5] - wcyc[0]), 64'd5);
        end

        // Idle gap then burst 0..3
        clear_log();
        tick(5);
        check("idle_no_stray", 64'(words.size() + dcyc.size()), 64'd0);
        do_start(0, 3);
        wait_idle("b0_3", 40);
        ex = '{8'h10, 8'h11, 8'h12, 8'h13};
        check_words("b0_3", ex);

        // Paused burst 8..12: en high 2, low 3, high
        clear_log();
        en = 1'b1;
        do_start(8, 12);
        tick(2);
        en = 1'b0;
        tick(3);
        en = 1'b1;
        wait_idle("b8_12", 40);
        ex = '{8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C};
        check_words("b8_12", ex);
        if (wcyc.size() == 5) begin
            check("b8_12_c0", 64'(wcyc[0]), 64'(s_edge + 2));
            check("b8_12_c1", 64'(wcyc[1]), 64'(s_edge + 3));
            check("b8_12_c2", 64'(wcyc[2]), 64'(s_edge + 7));
            check("b8_12_c4", 64'(wcyc[4]), 64'(s_edge + 9));
        end

        // Single word
        clear_log();
        do_start(7, 7);
        wait_idle("b7_7", 20);
        ex = '{8'h17};
        check_words("b7_7", ex);

        // Wrapping burst 62..1
        clear_log();
        do_start(62, 1);
        wait_idle("b62_1", 40);
        ex = '{8'h4E, 8'h4F, 8'h10, 8'h11};
        check_words("b62_1", ex);

        // Reset mid-burst, asserted between clock edges
        do_start(5, 10);
        tick(2);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {40'd0, valid, done, data, addr}, 64'd0);
        tick(2);
        rst_n = 1'b1;
        clear_log();
        tick(6);
        check("post_reset_silent", 64'(words.size() + dcyc.size()), 64'd0);
        do_start(2, 3);
        wait_idle("b2_3", 20);
        ex = '{8'h12, 8'h13};
        check_words("b2_3", ex);

        // Randomized bursts with random enable and range churn after start
        for (int b = 0; b < 25; b++) begin
            int s;
            int guard;
            s = int'($urandom_range(0, 63));
            do_start(s, (s + int'($urandom_range(0, 12))) % 64);
            guard = 0;
            while ((m_active || pend.size() != 0) && guard < 300) begin
                en = ($urandom_range(0, 3) != 0);
                si = 6'($urandom);
                ei = 6'($urandom);
                tick(1);
                guard++;
            end
            check("rand_burst_timeout", 64'(guard >= 300), 64'd0);
            en = 1'($urandom);
            tick(int'($urandom_range(0, 3)));
        end

        tick(3);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
